// File: rtl/cdbus_if.sv
`default_nettype none
// ============================================================================
// Module  : cdbus_if
// Brief   : Zero-wait-state CSR bus bundle between a host (master) and cdbus.
// Rev     : 1.0
// ============================================================================
interface cdbus_if;
  logic        chip_select;
  logic [3:0]  csr_address;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic        csr_write;
  logic [31:0] csr_writedata;

  modport master (output chip_select, csr_address, csr_read, csr_write, csr_writedata,
                  input  csr_readdata);
  modport slave  (input  chip_select, csr_address, csr_read, csr_write, csr_writedata,
                  output csr_readdata);
endinterface
`default_nettype wire

// File: rtl/cdbus.sv
`default_nettype none
// ============================================================================
// Module  : cdbus
// Brief   : CDBUS frame controller with UART 8N1 PHY, CRC-16/MODBUS, 256-byte TX/RX buffers.
// Rev     : 1.0
// ============================================================================
module cdbus (
  input  logic   clk,
  input  logic   reset_n,
  cdbus_if.slave csr,
  output logic   irq,
  input  logic   rx,
  output logic   tx,
  output logic   tx_en
);
  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_WAIT = 2'd1;
  localparam logic [1:0] TX_SEND = 2'd2;

  logic        promisc_q;
  logic [7:0]  idle_wait_q, filter_q;
  logic [15:0] div_q;
  logic [5:0]  int_mask_q;
  logic [7:0]  tx_buf [256];
  logic [7:0]  rx_buf [512];
  logic [7:0]  tx_wptr_q, rx_rptr_q;
  logic        rx_bank_q;
  logic [8:0]  rx_len_q;
  logic        rx_pending_q, rx_error_q, rx_lost_q, tx_done_q, bus_idle_q;
  logic [1:0]  tx_st_q;
  logic [9:0]  tx_sh_q;
  logic [3:0]  tx_bit_q, rx_bit_q;
  logic [15:0] tx_clk_q, rx_clk_q, idle_clk_q;
  logic [8:0]  tx_idx_q, rx_cnt_q;
  logic [15:0] tx_crc_q, rx_crc_q;
  logic        rx_m_q, rx_s_q, rx_p_q, rx_act_q, rx_drop_q;
  logic [7:0]  rx_sh_q, idle_bits_q, rx_dst_q, rx_flen_q;

  logic        wr_en, rd_en, tx_busy, tx_bit_end, tx_last, tx_launch, tx_load;
  logic        rx_fall, rx_mid, rx_byte_ok, bus_idle_d, frame_end, frame_ok, frame_hit;
  logic [15:0] div_eff;
  logic [8:0]  tx_n;
  logic [7:0]  tx_byte;
  logic [5:0]  flags;
  logic        unused_ok;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    wr_en      = csr.chip_select & csr.csr_write;
    rd_en      = csr.chip_select & csr.csr_read;
    div_eff    = (div_q < 16'd2) ? 16'd2 : div_q;
    tx_busy    = (tx_st_q == TX_SEND);
    flags      = {tx_busy, tx_done_q, rx_lost_q, rx_error_q, rx_pending_q, bus_idle_q};
    irq        = |(flags & int_mask_q);
    tx_en      = tx_busy;
    tx         = tx_busy ? tx_sh_q[0] : 1'b1;
    // Payload is src,dst,len,data; byte 2 of the buffer holds len.
    tx_n       = {1'b0, tx_buf[8'd2]} + 9'd3;
    tx_byte    = (tx_idx_q < tx_n) ? tx_buf[tx_idx_q[7:0]] :
                 (tx_idx_q == tx_n) ? tx_crc_q[7:0] : tx_crc_q[15:8];
    tx_bit_end = tx_busy && (tx_clk_q >= div_eff);
    tx_last    = (tx_idx_q == tx_n + 9'd2);
    tx_launch  = (tx_st_q == TX_WAIT) && bus_idle_q;
    tx_load    = tx_launch || (tx_bit_end && tx_bit_q == 4'd9 && !tx_last);
    rx_fall    = rx_p_q & ~rx_s_q;
    rx_mid     = rx_act_q && (rx_clk_q == {1'b0, div_eff[15:1]});
    rx_byte_ok = rx_mid && rx_bit_q == 4'd9 && rx_s_q;
    bus_idle_d = !rx_act_q && rx_s_q && (idle_bits_q >= idle_wait_q);
    frame_end  = bus_idle_d && !bus_idle_q;
    // CRC run over the trailing CRC bytes leaves a zero residue on a good frame.
    frame_ok   = (rx_cnt_q == {1'b0, rx_flen_q} + 9'd5) && (rx_crc_q == 16'h0000);
    frame_hit  = promisc_q || (rx_dst_q == filter_q) || (rx_dst_q == 8'hFF);
    unused_ok  = ^csr.csr_writedata[31:16];
  end

  always_comb begin
    csr.csr_readdata = 32'h0;
    case (csr.csr_address)
      4'd0:    csr.csr_readdata = 32'h1;
      4'd1:    csr.csr_readdata = {31'h0, promisc_q};
      4'd2:    csr.csr_readdata = {24'h0, idle_wait_q};
      4'd3:    csr.csr_readdata = {24'h0, filter_q};
      4'd4:    csr.csr_readdata = {16'h0, div_q};
      4'd5:    csr.csr_readdata = {26'h0, flags};
      4'd6:    csr.csr_readdata = {26'h0, int_mask_q};
      4'd7:    csr.csr_readdata = {24'h0, rx_buf[{rx_bank_q, rx_rptr_q}]};
      4'd11:   csr.csr_readdata = {23'h0, rx_len_q};
      default: ;
    endcase
  end

  // Receiver fills the bank opposite the one holding the pending frame.
  always_ff @(posedge clk) begin
    if (wr_en && csr.csr_address == 4'd8) tx_buf[tx_wptr_q] <= csr.csr_writedata[7:0];
    if (rx_byte_ok && !rx_drop_q && !rx_cnt_q[8]) rx_buf[{~rx_bank_q, rx_cnt_q[7:0]}] <= rx_sh_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      promisc_q <= 1'b0;  idle_wait_q <= 8'd10; filter_q <= 8'hFF; div_q <= 16'd433;
      int_mask_q <= 6'h0; tx_wptr_q <= 8'h0;    tx_done_q <= 1'b0; tx_st_q <= TX_IDLE;
      tx_sh_q <= 10'h3FF; tx_bit_q <= 4'd0;     tx_clk_q <= 16'd0; tx_idx_q <= 9'd0;
      tx_crc_q <= 16'hFFFF;
    end else begin
      if (wr_en) begin
        case (csr.csr_address)
          4'd1: promisc_q   <= csr.csr_writedata[0];
          4'd2: idle_wait_q <= csr.csr_writedata[7:0];
          4'd3: filter_q    <= csr.csr_writedata[7:0];
          4'd4: div_q       <= csr.csr_writedata[15:0];
          4'd6: int_mask_q  <= csr.csr_writedata[5:0];
          4'd8: if (tx_wptr_q != 8'hFF) tx_wptr_q <= tx_wptr_q + 8'd1;
          4'd10: begin
            if (csr.csr_writedata[0]) tx_wptr_q <= 8'h0;
            if (csr.csr_writedata[1] && !tx_busy) tx_st_q <= TX_WAIT;
            if (csr.csr_writedata[2]) tx_done_q <= 1'b0;
          end
          default: ;
        endcase
      end
      if (tx_launch) tx_st_q <= TX_SEND;
      if (tx_busy) begin
        tx_clk_q <= tx_bit_end ? 16'd0 : tx_clk_q + 16'd1;
        if (tx_bit_end) begin
          tx_bit_q <= tx_bit_q + 4'd1;
          tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
          if (tx_bit_q == 4'd9 && tx_last) begin
            tx_st_q <= TX_IDLE; tx_done_q <= 1'b1; tx_idx_q <= 9'd0;
            tx_crc_q <= 16'hFFFF; tx_bit_q <= 4'd0;
          end
        end
      end
      if (tx_load) begin
        tx_sh_q  <= {1'b1, tx_byte, 1'b0};
        tx_bit_q <= 4'd0;
        tx_clk_q <= 16'd0;
        tx_idx_q <= tx_idx_q + 9'd1;
        if (tx_idx_q < tx_n) tx_crc_q <= crc_upd(tx_crc_q, tx_byte);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m_q <= 1'b1; rx_s_q <= 1'b1; rx_p_q <= 1'b1; rx_act_q <= 1'b0; rx_drop_q <= 1'b0;
      rx_bit_q <= 4'd0; rx_clk_q <= 16'd0; idle_clk_q <= 16'd0; idle_bits_q <= 8'd0;
      rx_sh_q <= 8'h0; rx_dst_q <= 8'h0; rx_flen_q <= 8'h0; rx_cnt_q <= 9'd0;
      rx_crc_q <= 16'hFFFF; bus_idle_q <= 1'b0; rx_pending_q <= 1'b0; rx_error_q <= 1'b0;
      rx_lost_q <= 1'b0; rx_bank_q <= 1'b0; rx_rptr_q <= 8'h0; rx_len_q <= 9'd0;
    end else begin
      rx_m_q <= rx; rx_s_q <= rx_m_q; rx_p_q <= rx_s_q;
      bus_idle_q <= bus_idle_d;
      if (rx_act_q || !rx_s_q) begin
        idle_clk_q <= 16'd0; idle_bits_q <= 8'd0;
      end else if (idle_clk_q >= div_eff) begin
        idle_clk_q <= 16'd0;
        if (idle_bits_q != 8'hFF) idle_bits_q <= idle_bits_q + 8'd1;
      end else begin
        idle_clk_q <= idle_clk_q + 16'd1;
      end
      // Start detection already spent one clock of the start bit.
      if (!rx_act_q) begin
        if (rx_fall) begin rx_act_q <= 1'b1; rx_bit_q <= 4'd0; rx_clk_q <= 16'd1; end
      end else begin
        rx_clk_q <= (rx_clk_q >= div_eff) ? 16'd0 : rx_clk_q + 16'd1;
        if (rx_clk_q >= div_eff) rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_mid) begin
          if (rx_bit_q == 4'd0) begin
            if (rx_s_q) rx_act_q <= 1'b0;
          end else if (rx_bit_q == 4'd9) begin
            rx_act_q <= 1'b0;
            if (!rx_s_q) begin
              rx_error_q <= 1'b1; rx_drop_q <= 1'b1;
            end else if (!rx_drop_q) begin
              if (rx_cnt_q != 9'd259) rx_cnt_q <= rx_cnt_q + 9'd1;
              if (rx_cnt_q == 9'd1) rx_dst_q <= rx_sh_q;
              if (rx_cnt_q == 9'd2) rx_flen_q <= rx_sh_q;
              rx_crc_q <= crc_upd(rx_crc_q, rx_sh_q);
            end
          end else begin
            rx_sh_q <= {rx_s_q, rx_sh_q[7:1]};
          end
        end
      end
      if (rd_en && csr.csr_address == 4'd7) rx_rptr_q <= rx_rptr_q + 8'd1;
      if (wr_en && csr.csr_address == 4'd9) begin
        if (csr.csr_writedata[0]) rx_rptr_q    <= 8'h0;
        if (csr.csr_writedata[1]) rx_pending_q <= 1'b0;
        if (csr.csr_writedata[2]) rx_lost_q    <= 1'b0;
        if (csr.csr_writedata[3]) rx_error_q   <= 1'b0;
      end
      if (frame_end) begin
        rx_cnt_q <= 9'd0; rx_crc_q <= 16'hFFFF; rx_drop_q <= 1'b0;
        if (!rx_drop_q && rx_cnt_q != 9'd0) begin
          if (!frame_ok) begin
            rx_error_q <= 1'b1;
          end else if (frame_hit) begin
            if (rx_pending_q) begin
              rx_lost_q <= 1'b1;
            end else begin
              rx_pending_q <= 1'b1; rx_bank_q <= ~rx_bank_q;
              rx_len_q <= rx_cnt_q - 9'd2; rx_rptr_q <= 8'h0;
            end
          end
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_cdbus.sv
`default_nettype none
// Two cross-wired cdbus instances; m1 rx can be switched to a bench-driven serial injector.
module tb_cdbus;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  cdbus_if b0();
  cdbus_if b1();
  logic irq0, irq1, tx0, tx1, txen0, txen1;
  logic inj = 1'b1;
  logic inj_sel = 1'b0;
  logic rx1;
  assign rx1 = inj_sel ? inj : tx0;

  cdbus u0 (.clk(clk), .reset_n(reset_n), .csr(b0), .irq(irq0), .rx(tx1), .tx(tx0), .tx_en(txen0));
  cdbus u1 (.clk(clk), .reset_n(reset_n), .csr(b1), .irq(irq1), .rx(rx1), .tx(tx1), .tx_en(txen1));

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_bus();
    b0.chip_select = 1'b0; b0.csr_read = 1'b0; b0.csr_write = 1'b0;
    b1.chip_select = 1'b0; b1.csr_read = 1'b0; b1.csr_write = 1'b0;
  endtask

  task automatic wr(input int m, input logic [3:0] a, input logic [31:0] d);
    if (m == 0) begin
      b0.chip_select = 1'b1; b0.csr_write = 1'b1; b0.csr_address = a; b0.csr_writedata = d;
    end else begin
      b1.chip_select = 1'b1; b1.csr_write = 1'b1; b1.csr_address = a; b1.csr_writedata = d;
    end
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic rd(input int m, input logic [3:0] a, output logic [31:0] d);
    if (m == 0) begin
      b0.chip_select = 1'b1; b0.csr_read = 1'b1; b0.csr_address = a;
    end else begin
      b1.chip_select = 1'b1; b1.csr_read = 1'b1; b1.csr_address = a;
    end
    #2;
    d = (m == 0) ? b0.csr_readdata : b1.csr_readdata;
    @(posedge clk); #1;
    idle_bus();
  endtask

  // Bit-serial CRC-16/MODBUS reference.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r = r >> 1;
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  // One UART byte at DIV=2 (3 clocks per bit).
  task automatic ser(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      inj = fr[i];
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic inj_frame(input logic [7:0] dst, input int n, input logic [7:0] d0,
                           input logic [15:0] flip, input bit store);
    logic [7:0] f[$];
    logic [15:0] c;
    f = {};
    f.push_back(8'h02); f.push_back(dst); f.push_back(8'(n));
    for (int i = 0; i < n; i++) f.push_back(d0 + 8'(i));
    c = 16'hFFFF;
    foreach (f[i]) c = crc_byte(c, f[i]);
    if (store) foreach (f[i]) exp_q.push_back(f[i]);
    c = c ^ flip;
    f.push_back(c[7:0]); f.push_back(c[15:8]);
    inj_sel = 1'b1;
    @(posedge clk); #1;
    foreach (f[i]) ser(f[i]);
    repeat (60) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    logic [31:0] d;
    logic [7:0] e;
    rd(1, 4'd11, d);
    chk({tag, "_len"}, d, 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rd(1, 4'd7, d);
      chk({tag, "_data"}, d, {24'h0, e});
    end
  endtask

  initial begin
    logic [31:0] d;
    int k;
    b0.csr_address = 4'd0; b0.csr_writedata = 32'h0;
    b1.csr_address = 4'd0; b1.csr_writedata = 32'h0;
    idle_bus();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx0), 32'h1);
    chk("rst_txen", 32'(txen0), 32'h0);
    chk("rst_irq", 32'(irq0), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    rd(0, 4'd0, d);  chk("version", d, 32'h1);
    rd(0, 4'd1, d);  chk("setting", d, 32'h0);
    rd(0, 4'd2, d);  chk("idle_wait", d, 32'd10);
    rd(0, 4'd3, d);  chk("filter", d, 32'hFF);
    rd(0, 4'd4, d);  chk("div", d, 32'd433);
    rd(0, 4'd5, d);  chk("int_flag", d, 32'h0);
    rd(0, 4'd6, d);  chk("int_mask", d, 32'h0);
    rd(0, 4'd11, d); chk("rx_len", d, 32'h0);
    rd(0, 4'd13, d); chk("unmapped", d, 32'h0);

    wr(0, 4'd4, 32'd2);
    wr(1, 4'd4, 32'd2);
    wr(1, 4'd3, 32'h01);
    wr(1, 4'd6, 32'h02);

    // Loopback m0 -> m1
    wr(0, 4'd10, 32'h1);
    wr(0, 4'd8, 32'h00); exp_q.push_back(8'h00);
    wr(0, 4'd8, 32'h01); exp_q.push_back(8'h01);
    wr(0, 4'd8, 32'h01); exp_q.push_back(8'h01);
    wr(0, 4'd8, 32'hCD); exp_q.push_back(8'hCD);
    wr(0, 4'd10, 32'h2);
    k = 0;
    while (!irq1 && k < 3000) begin @(posedge clk); #1; k++; end
    chk("lb_irq", 32'(irq1), 32'h1);
    rd(1, 4'd5, d);
    chk("lb_pending", 32'(d[1]), 32'h1);
    chk("lb_error", 32'(d[2]), 32'h0);
    drain("lb");
    rd(0, 4'd5, d);
    chk("m0_txdone", 32'(d[4]), 32'h1);
    chk("m0_txbusy", 32'(d[5]), 32'h0);
    chk("m0_txen_idle", 32'(txen0), 32'h0);
    wr(1, 4'd9, 32'h2);
    chk("irq_clr", 32'(irq1), 32'h0);

    // Corrupted CRC
    inj_frame(8'h01, 1, 8'h55, 16'h0001, 1'b0);
    rd(1, 4'd5, d);
    chk("crc_error", 32'(d[2]), 32'h1);
    chk("crc_pending", 32'(d[1]), 32'h0);
    wr(1, 4'd9, 32'h8);
    rd(1, 4'd5, d);
    chk("err_clr", 32'(d[2]), 32'h0);

    // Address filter and promiscuous mode
    inj_frame(8'h05, 0, 8'h00, 16'h0000, 1'b0);
    rd(1, 4'd5, d);
    chk("filt_pending", 32'(d[1]), 32'h0);
    chk("filt_error", 32'(d[2]), 32'h0);
    wr(1, 4'd1, 32'h1);
    inj_frame(8'h05, 0, 8'h00, 16'h0000, 1'b1);
    rd(1, 4'd5, d);
    chk("prom_pending", 32'(d[1]), 32'h1);
    drain("prom");
    wr(1, 4'd9, 32'h2);
    wr(1, 4'd1, 32'h0);

    // Second frame while one is pending
    inj_frame(8'h01, 2, 8'hA0, 16'h0000, 1'b1);
    inj_frame(8'hFF, 0, 8'h00, 16'h0000, 1'b0);
    rd(1, 4'd5, d);
    chk("lost_pending", 32'(d[1]), 32'h1);
    chk("lost_flag", 32'(d[3]), 32'h1);
    chk("lost_error", 32'(d[2]), 32'h0);
    drain("lost");
    wr(1, 4'd9, 32'h6);
    rd(1, 4'd5, d);
    chk("lost_clr", 32'(d[3:1]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cdbus.md
CDBUS -- requirements
Module: cdbus

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (all logic on rising edge).
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: chip_select  in  1  gates csr_read/csr_write; ignored when low.
REQ-004 SHALL have: csr_address  in  4  word register index.
REQ-005 SHALL have: csr_read  in  1; csr_readdata  out  32, combinational, 0 wait states; csr_write  in  1; csr_writedata  in  32.
REQ-006 SHALL have: irq  out  1  level interrupt.
REQ-007 SHALL have: rx  in  1  serial input, idle high; tx  out  1  serial output, idle high; tx_en  out  1  high while driving a frame.

Function
REQ-008 SHALL map registers as: 0 VERSION RO 0x00000001; 1 SETTING RW [0]=promiscuous; 2 IDLE_WAIT RW [7:0] bit-times, default 10; 3 FILTER RW [7:0], default 0xFF; 4 DIV RW [15:0] clocks-per-bit minus 1, default 433, values <2 treated as 2.
REQ-009 SHALL map: 5 INT_FLAG RO [0] bus_idle, [1] rx_pending, [2] rx_error, [3] rx_lost, [4] tx_done, [5] tx_busy; 6 INT_MASK RW [5:0], default 0; 7 RX_DATA RO; 8 TX_DATA WO; 9 RX_CTRL WO; 10 TX_CTRL WO; 11 RX_LEN RO [8:0]; unmapped reads return 0.
REQ-010 SHALL drive irq = |(INT_FLAG & INT_MASK), combinational.
REQ-011 SHALL serialize bytes as UART 8N1: start 0, data LSB first, stop 1, each bit DIV+1 clocks.
REQ-012 SHALL use frame format src, dst, len, data[len], crc_lo, crc_hi; CRC-16/MODBUS (poly 0xA001 reflected, init 0xFFFF) over src..data.
REQ-013 SHALL hold 256-byte TX and RX buffers; write to TX_DATA stores [7:0] at tx write pointer and increments it, saturating at 255.
REQ-014 SHALL, on TX_CTRL write: [0]=1 clear tx write pointer; [1]=1 start transmit; [2]=1 clear tx_done; start ignored while tx_busy.
REQ-015 SHALL, after start, wait until bus_idle, then set tx_busy, tx_en=1, send buffer bytes 0..(2+byte2), then CRC low, CRC high; tx_en drops with end of last stop bit, tx_busy clears, tx_done sets same cycle.
REQ-016 SHALL synchronize rx with two flops, detect start on falling edge, sample mid-bit, reject start if not low at mid-bit; stop bit 0 sets rx_error and aborts frame.
REQ-017 SHALL assert bus_idle when rx has been high >= IDLE_WAIT bit-times and no byte is in progress; bus_idle clears on start bit.
REQ-018 SHALL end a received frame when bus_idle asserts; frame valid iff byte count = len+5 and CRC matches; otherwise set rx_error (frames of 0 bytes ignored, >258 bytes error).
REQ-019 SHALL accept valid frame iff promiscuous or dst=FILTER or dst=0xFF; accepted frame with rx_pending=0 is stored (without CRC), RX_LEN=len+3, rx_pending set; with rx_pending=1 it is dropped and rx_lost set.
REQ-020 SHALL receive into a shadow area so a frame in progress never corrupts an unreleased pending frame.
REQ-021 SHALL, on csr_read of RX_DATA, return byte at rx read pointer in [7:0] and increment pointer after the read cycle.
REQ-022 SHALL, on RX_CTRL write: [0] reset read pointer; [1] release buffer, clear rx_pending; [2] clear rx_lost; [3] clear rx_error.
REQ-023 SHALL, in full-duplex use, receive own transmissions only through rx; no internal loopback.

Reset
REQ-024 SHALL on reset_n low: tx=1, tx_en=0, irq=0, all flags 0 except bus_idle 0, pointers 0, registers at defaults; buffer contents undefined.
REQ-025 SHALL abort any transfer immediately on reset; outputs return to idle values asynchronously.

Verification
REQ-026 Reset: read all registers -> VERSION 1, IDLE_WAIT 10, FILTER 0xFF, DIV 433, INT_FLAG 0, tx=1, tx_en=0.
REQ-027 Loopback two instances, DIV=2: m0 sends 00,01,01,CD -> m1 (FILTER 01) rx_pending=1, RX_LEN 4, RX_DATA 00,01,01,CD; m0 tx_done=1.
REQ-028 Inject frame with flipped CRC bit -> rx_error=1, rx_pending=0.
REQ-029 dst 0x05, FILTER 0x01, promiscuous 0 -> not stored; set promiscuous -> stored.
REQ-030 Two valid frames without release -> first retained, rx_lost=1.
REQ-031 INT_MASK=0x02, frame received -> irq=1; RX_CTRL=0x02 -> irq=0 next cycle.
